// File: rtl/meter_monitor.sv
// rtl/meter_monitor.sv - periodic meter sampler with power, peak and debounced alarm tracking
module meter_monitor #(
    parameter int SAMPLE_PERIOD = 500000,
    parameter int OV_LIMIT      = 3500,
    parameter int OC_LIMIT      = 3000,
    parameter int TRIP_COUNT    = 3,
    parameter int ACK_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        meter_start,
    input  logic        meter_busy,
    input  logic [11:0] meter_data_v,
    input  logic [11:0] meter_data_i,
    output logic        sample_valid,
    output logic [11:0] volt,
    output logic [11:0] curr,
    output logic [23:0] power,
    output logic [11:0] v_peak,
    output logic [11:0] i_peak,
    input  logic        clear_peaks,
    output logic        ov_alarm,
    output logic        oc_alarm,
    output logic        overrun,
    output logic        meter_fault,
    input  logic        clear_alarm,
    output logic [15:0] sample_count
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;

    logic [2:0]    state;
    logic [PW-1:0] per_cnt;
    logic          tick;
    logic [AW-1:0] ack_cnt;
    logic [11:0]   cap_v;
    logic [11:0]   cap_i;
    logic [3:0]    trip_v;
    logic [3:0]    trip_i;
    logic [3:0]    trip_v_nxt;
    logic [3:0]    trip_i_nxt;
    logic          commit;

    assign tick         = enable && (per_cnt == PW'(SAMPLE_PERIOD - 1));
    // Results are committed on the edge entering UPDATE so they are valid alongside sample_valid.
    assign commit       = (state == S_CAPTURE);
    assign meter_start  = (state == S_START);
    assign sample_valid = (state == S_UPDATE);

    always_comb begin
        trip_v_nxt = 4'd0;
        trip_i_nxt = 4'd0;
        if (cap_v > 12'(OV_LIMIT))
            trip_v_nxt = (trip_v == 4'(TRIP_COUNT)) ? trip_v : trip_v + 4'd1;
        if (cap_i > 12'(OC_LIMIT))
            trip_i_nxt = (trip_i == 4'(TRIP_COUNT)) ? trip_i : trip_i + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            per_cnt <= '0;
        else if (!enable || tick)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ack_cnt     <= '0;
            cap_v       <= '0;
            cap_i       <= '0;
            overrun     <= 1'b0;
            meter_fault <= 1'b0;
        end else begin
            if (clear_alarm) begin
                overrun     <= 1'b0;
                meter_fault <= 1'b0;
            end
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE:      if (tick) state <= S_START;
                S_START: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (meter_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        meter_fault <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!meter_busy) begin
                        cap_v <= meter_data_v;
                        cap_i <= meter_data_i;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE:   state <= S_UPDATE;
                S_UPDATE:    state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            volt         <= '0;
            curr         <= '0;
            power        <= '0;
            v_peak       <= '0;
            i_peak       <= '0;
            sample_count <= '0;
            trip_v       <= '0;
            trip_i       <= '0;
            ov_alarm     <= 1'b0;
            oc_alarm     <= 1'b0;
        end else if (commit) begin
            volt         <= cap_v;
            curr         <= cap_i;
            power        <= 24'(cap_v) * 24'(cap_i);
            sample_count <= sample_count + 16'd1;
            v_peak       <= (clear_peaks || cap_v > v_peak) ? cap_v : v_peak;
            i_peak       <= (clear_peaks || cap_i > i_peak) ? cap_i : i_peak;
            // A trip on this sample wins over a simultaneous clear; counters still restart.
            trip_v       <= clear_alarm ? 4'd0 : trip_v_nxt;
            trip_i       <= clear_alarm ? 4'd0 : trip_i_nxt;
            ov_alarm     <= (trip_v_nxt == 4'(TRIP_COUNT)) || (ov_alarm && !clear_alarm);
            oc_alarm     <= (trip_i_nxt == 4'(TRIP_COUNT)) || (oc_alarm && !clear_alarm);
        end else begin
            if (clear_peaks) begin
                v_peak <= '0;
                i_peak <= '0;
            end
            if (clear_alarm) begin
                trip_v   <= '0;
                trip_i   <= '0;
                ov_alarm <= 1'b0;
                oc_alarm <= 1'b0;
            end
        end
    end
endmodule
